// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
// Tracks the destination registers of the instructions in execute (E),
// memory (M) and writeback (W), raises a one-cycle load-use stall, flushes
// decode on a taken branch, and produces registered operand-forwarding
// selects for the instruction entering execute.
// Optional build macro: HAZARD_STALL_CNT_EN adds a saturating 32-bit
// stall_cnt output counting load-use stall or flush cycles.
module hazard_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rs1_decode,
    input  logic [4:0]  rs2_decode,
    input  logic        rs1_used,
    input  logic        rs2_used,
    input  logic [4:0]  rd_decode,
    input  logic        rd_we_decode,
    input  logic        is_load_decode,
    input  logic        decode_valid,
    input  logic        branch_taken,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall_fetch,
    output logic        stall_decode,
    output logic        bubble_execute,
    output logic        flush_decode
`ifdef HAZARD_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       we;
        logic       is_load;
    } slot_t;

    localparam logic [1:0] SRC_REGFILE = 2'b00;
    localparam logic [1:0] SRC_MEM     = 2'b01;
    localparam logic [1:0] SRC_WB      = 2'b10;

    // Index 0 = E, 1 = M, 2 = W. W is kept so the pipeline picture is
    // complete; nothing needs to forward from it because the register file
    // write lands before the decode read.
    slot_t      slots_reg [0:2];
    slot_t      e_next;
    logic [1:0] fwd_a_reg, fwd_b_reg;
    logic [1:0] fwd_a_next, fwd_b_next;
    logic       e_prod, m_prod, load_use, flush, stall, e_load;

    // Choose the operand source for one decode source register. The slot in
    // E is nearer than M and wins; a load in E cannot forward (its data is
    // not ready), which is why such a match stalls instead.
    function automatic logic [1:0] pick_src(
        input logic [4:0] rs,
        input logic       used,
        input slot_t      e_slot,
        input logic       e_is_prod,
        input slot_t      m_slot,
        input logic       m_is_prod
    );
        logic [1:0] src;
        src = SRC_REGFILE;
        if (used && (rs != 5'd0)) begin
            if (e_is_prod && !e_slot.is_load && (e_slot.rd == rs))
                src = SRC_MEM;
            else if (m_is_prod && (m_slot.rd == rs))
                src = SRC_WB;
        end
        return src;
    endfunction

    assign e_prod = slots_reg[0].valid && slots_reg[0].we && (slots_reg[0].rd != 5'd0);
    assign m_prod = slots_reg[1].valid && slots_reg[1].we && (slots_reg[1].rd != 5'd0);

    // Load-use hazard: a load in E writes a register decode wants to read.
    assign load_use = decode_valid && e_prod && slots_reg[0].is_load &&
                      ((rs1_used && (rs1_decode == slots_reg[0].rd)) ||
                       (rs2_used && (rs2_decode == slots_reg[0].rd)));

    // Gate with reset so the combinational outputs stay low during reset
    // even if branch_taken is driven.
    assign flush  = branch_taken && reset;
    assign stall  = load_use && !flush;
    assign e_load = decode_valid && !load_use && !flush;

    assign stall_fetch    = stall;
    assign stall_decode   = stall;
    assign bubble_execute = stall || flush;
    assign flush_decode   = flush;
    assign fwd_a_sel      = fwd_a_reg;
    assign fwd_b_sel      = fwd_b_reg;

    // Next E slot and next forwarding selects; a bubble or flush yields an
    // invalid slot and regfile selects.
    always_comb begin
        e_next     = '0;
        fwd_a_next = SRC_REGFILE;
        fwd_b_next = SRC_REGFILE;
        if (e_load) begin
            e_next.valid   = 1'b1;
            e_next.rd      = rd_decode;
            e_next.we      = rd_we_decode;
            e_next.is_load = is_load_decode;
            fwd_a_next = pick_src(rs1_decode, rs1_used, slots_reg[0], e_prod,
                                  slots_reg[1], m_prod);
            fwd_b_next = pick_src(rs2_decode, rs2_used, slots_reg[0], e_prod,
                                  slots_reg[1], m_prod);
        end
    end

    // Advance the slot pipeline and register the forwarding selects.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) slots_reg[i] <= '0;
            fwd_a_reg <= SRC_REGFILE;
            fwd_b_reg <= SRC_REGFILE;
        end else begin
            slots_reg[2] <= slots_reg[1];
            slots_reg[1] <= slots_reg[0];
            slots_reg[0] <= e_next;
            fwd_a_reg    <= fwd_a_next;
            fwd_b_reg    <= fwd_b_next;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt_reg;

    // Count cycles lost to a load-use stall or a flush, saturating at all-ones.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            stall_cnt_reg <= '0;
        else if ((load_use || flush) && (stall_cnt_reg != 32'hFFFF_FFFF))
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
